// File: rtl/btn_debounce_pkg.sv
// Shared types for the push-button debouncer: channel FSM states and counter sizing.
// Build option BTN_DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser per channel.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One debouncer channel: optional synchroniser, qualification FSM, stability counter.
// BTN_DEBOUNCE_SYNC_EN selects the 2-flop synchroniser; otherwise btn_raw is used directly.
module debounce_cell
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db_out,
    output logic busy
);

    localparam int              CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic s;

`ifdef BTN_DEBOUNCE_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn_raw};
        end
    end

    assign s = sync_reg[1];
`else
    assign s = btn_raw;
`endif

    db_state_t       state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            db_out_reg;
    logic            busy_reg;

    // busy_reg tracks the state being entered, so it is high exactly in WAIT_HI/WAIT_LO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= ST_LO;
            cnt_reg    <= '0;
            db_out_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_LO: begin
                    if (s) begin
                        state_reg <= WAIT_HI;
                        cnt_reg   <= CNT_ONE;
                        busy_reg  <= 1'b1;
                    end else begin
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_reg <= ST_LO;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg  <= ST_HI;
                        db_out_reg <= 1'b1;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        state_reg <= WAIT_LO;
                        cnt_reg   <= CNT_ONE;
                        busy_reg  <= 1'b1;
                    end else begin
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_reg <= ST_HI;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg  <= ST_LO;
                        db_out_reg <= 1'b0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg  <= ST_LO;
                    cnt_reg    <= '0;
                    db_out_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign db_out = db_out_reg;
    assign busy   = busy_reg;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer; one independent debounce_cell per channel.
// BTN_DEBOUNCE_SYNC_EN enables per-channel input synchronisers.
module btn_debounce
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] busy
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            debounce_cell #(
                .STABLE_CYCLES(STABLE_CYCLES)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .btn_raw(btn_raw[gi]),
                .db_out (db_out[gi]),
                .busy   (busy[gi])
            );
        end
    endgenerate

endmodule
